// File: rtl/aes_pkg.sv
// Shared AES types, constants and the xtime helper used by the key schedule
// and the S-box.
package aes_pkg;

    typedef logic [7:0]  aes_byte_t;
    typedef logic [31:0] aes_word_t;

    localparam aes_byte_t  RCON_INIT  = 8'h01;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } key_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8)
// followed by the affine transform. Shared with the SubBytes stage.
module aes_sbox
    import aes_pkg::*;
(
    input  aes_byte_t a,
    output aes_byte_t s
);

    function automatic aes_byte_t gf_mul(input aes_byte_t x, input aes_byte_t y);
        aes_byte_t p;
        aes_byte_t m;
        p = 8'h00;
        m = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ m;
            m = xtime(m);
        end
        return p;
    endfunction

    // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
    function automatic aes_byte_t gf_inv(input aes_byte_t x);
        aes_byte_t r;
        aes_byte_t q;
        r = 8'h01;
        q = x;
        for (int i = 1; i < 8; i++) begin
            q = gf_mul(q, q);
            r = gf_mul(r, q);
        end
        return r;
    endfunction

    function automatic aes_byte_t affine(input aes_byte_t b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign s = affine(gf_inv(a));

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: emits round keys 0..NR, one per accepted
// transfer. Define AES_KEY_REPLAY_EN to enable restarting from a cached key.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [7:0]   K0,
    output logic [7:0]   K1,
    output logic [7:0]   K2,
    output logic [7:0]   K3,
    output logic [7:0]   K4,
    output logic [7:0]   K5,
    output logic [7:0]   K6,
    output logic [7:0]   K7,
    output logic [7:0]   K8,
    output logic [7:0]   K9,
    output logic [7:0]   KA,
    output logic [7:0]   KB,
    output logic [7:0]   KC,
    output logic [7:0]   KD,
    output logic [7:0]   KE,
    output logic [7:0]   KF,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    input  logic         replay
);

    localparam logic [3:0] LAST = 4'(NR);

    key_state_t   state_reg;
    logic [127:0] key_reg;
    logic [127:0] key_next;
    logic [3:0]   round_reg;
    aes_byte_t    rcon_reg;
    logic         key_ready_reg;
    logic         rk_valid_reg;

    aes_word_t w0, w1, w2, w3;
    aes_word_t rot_word;
    aes_word_t sub_word;
    aes_word_t t_word;
    aes_word_t n0, n1, n2, n3;

    assign w0 = key_reg[127:96];
    assign w1 = key_reg[95:64];
    assign w2 = key_reg[63:32];
    assign w3 = key_reg[31:0];
    assign rot_word = {w3[23:0], w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .a (rot_word[31-8*gi -: 8]),
                .s (sub_word[31-8*gi -: 8])
            );
        end
    endgenerate

    assign t_word   = sub_word ^ {rcon_reg, 24'h000000};
    assign n0       = w0 ^ t_word;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign key_next = {n0, n1, n2, n3};

`ifdef AES_KEY_REPLAY_EN
    logic [127:0] cache_reg;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cache_reg <= '0;
        else if (!replay && state_reg == IDLE && key_valid)
            cache_reg <= key_in;
    end
`else
    logic unused_replay;
    assign unused_replay = replay;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            key_reg       <= '0;
            round_reg     <= 4'd0;
            rcon_reg      <= RCON_INIT;
            key_ready_reg <= 1'b1;
            rk_valid_reg  <= 1'b0;
        end else
`ifdef AES_KEY_REPLAY_EN
        // Replay outranks both a pending transfer and a new key.
        if (replay) begin
            state_reg     <= ACTIVE;
            key_reg       <= cache_reg;
            round_reg     <= 4'd0;
            rcon_reg      <= RCON_INIT;
            key_ready_reg <= 1'b0;
            rk_valid_reg  <= 1'b1;
        end else
`endif
        begin
            case (state_reg)
                IDLE: begin
                    if (key_valid) begin
                        state_reg     <= ACTIVE;
                        key_reg       <= key_in;
                        round_reg     <= 4'd0;
                        rcon_reg      <= RCON_INIT;
                        key_ready_reg <= 1'b0;
                        rk_valid_reg  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (rk_ready) begin
                        if (round_reg == LAST) begin
                            // Last key stays visible on the outputs after the hand-off.
                            state_reg     <= IDLE;
                            key_ready_reg <= 1'b1;
                            rk_valid_reg  <= 1'b0;
                        end else begin
                            key_reg   <= key_next;
                            round_reg <= round_reg + 4'd1;
                            rcon_reg  <= xtime(rcon_reg);
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    key_ready_reg <= 1'b1;
                    rk_valid_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready = key_ready_reg;
    assign rk_valid  = rk_valid_reg;
    assign rk_round  = round_reg;

    assign K0 = key_reg[127:120];
    assign K1 = key_reg[119:112];
    assign K2 = key_reg[111:104];
    assign K3 = key_reg[103:96];
    assign K4 = key_reg[95:88];
    assign K5 = key_reg[87:80];
    assign K6 = key_reg[79:72];
    assign K7 = key_reg[71:64];
    assign K8 = key_reg[63:56];
    assign K9 = key_reg[55:48];
    assign KA = key_reg[47:40];
    assign KB = key_reg[39:32];
    assign KC = key_reg[31:24];
    assign KD = key_reg[23:16];
    assign KE = key_reg[15:8];
    assign KF = key_reg[7:0];

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: FIPS-197 vectors, backpressure,
// ignored inputs, reset abort and random keys against a word-array key model.
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [7:0]   K0, K1, K2, K3, K4, K5, K6, K7;
    logic [7:0]   K8, K9, KA, KB, KC, KD, KE, KF;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic         replay = 1'b0;

    logic [127:0] dut_key;
    logic [7:0]   sb [0:255];
    logic [127:0] cap [0:10];
    int           n_vec = 0;
    int           n_bad = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    always #5 clk = ~clk;

    assign dut_key = {K0, K1, K2, K3, K4, K5, K6, K7, K8, K9, KA, KB, KC, KD, KE, KF};

    aes_key_expand_seq #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .K0 (K0), .K1 (K1), .K2 (K2), .K3 (K3),
        .K4 (K4), .K5 (K5), .K6 (K6), .K7 (K7),
        .K8 (K8), .K9 (K9), .KA (KA), .KB (KB),
        .KC (KC), .KD (KD), .KE (KE), .KF (KF),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .replay    (replay)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (y[i]) p = p ^ (16'(x) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // S-box table from brute-force inversion plus the bitwise affine rule.
    task automatic build_sbox();
        logic [7:0] inv, s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sb[x] = s;
        end
    endtask

    // Full 44-word FIPS-197 expansion; returns words 4r..4r+3.
    function automatic logic [127:0] ref_key(input logic [127:0] k, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Load a key and walk the schedule; negative round arguments disable a feature.
    task automatic run_key(input logic [127:0] key, input bit rnd_ready,
                           input int stall_round, input int stall_len,
                           input int inj_round, input int rst_round,
                           input int replay_round);
        int  r;
        int  stalls;
        bit  done;
        bit  replayed;
        bit  rdy;
        check("key_ready_idle", 128'(key_ready), 128'(1));
        key_in    = key;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        r = 0; stalls = 0; done = 1'b0; replayed = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            check("rk_valid", 128'(rk_valid), 128'(1));
            check("key_ready_busy", 128'(key_ready), 128'(0));
            check("rk_round", 128'(rk_round), 128'(r));
            check($sformatf("round_key_%0d", r), dut_key, ref_key(key, r));
            cap[r] = dut_key;
            if (r == rst_round) begin
                rst_n    = 1'b0;
                rk_ready = 1'b1;
                tick();
                rst_n    = 1'b1;
                rk_ready = 1'b0;
                check("rst_rk_valid", 128'(rk_valid), 128'(0));
                check("rst_key_ready", 128'(key_ready), 128'(1));
                check("rst_key", dut_key, 128'(0));
                check("rst_round", 128'(rk_round), 128'(0));
                $display("reset applied at round %0d", r);
                return;
            end
            if (r == replay_round && !replayed) begin
                replay   = 1'b1;
                rk_ready = 1'b1;
                tick();
                replay   = 1'b0;
                replayed = 1'b1;
                $display("replay issued at round %0d", r);
                r = 0;
                continue;
            end
            rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (r == stall_round && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end
            key_valid = (r == inj_round);
            key_in    = ~key;
            rk_ready  = rdy;
            tick();
            key_valid = 1'b0;
            if (rdy) begin
                $display("round %0d key %032h", r, cap[r]);
                if (r == 10) done = 1'b1;
                else r++;
            end
        end
        if (!done) check("timeout", 128'(0), 128'(1));
        check("end_rk_valid", 128'(rk_valid), 128'(0));
        check("end_key_ready", 128'(key_ready), 128'(1));
        check("end_round", 128'(rk_round), 128'(10));
        check("end_key_hold", dut_key, ref_key(key, 10));
        rk_ready = 1'b1;
        tick();
        rk_ready = 1'b0;
        check("idle_ignores_ready", 128'(rk_valid), 128'(0));
        check("idle_round_hold", 128'(rk_round), 128'(10));
    endtask

    initial begin
        build_sbox();
        tick();
        tick();
        check("reset_rk_valid", 128'(rk_valid), 128'(0));
        check("reset_key_ready", 128'(key_ready), 128'(1));
        check("reset_key", dut_key, 128'(0));
        check("reset_round", 128'(rk_round), 128'(0));
        rst_n = 1'b1;
        tick();

        run_key(FIPS_KEY, 1'b0, -1, 0, -1, -1, -1);
        check("fips_round1", cap[1], FIPS_R1);
        check("fips_round10", cap[10], FIPS_R10);

        run_key(128'(0), 1'b0, -1, 0, -1, -1, -1);
        check("zero_round1", cap[1], ZERO_R1);

        run_key(FIPS_KEY, 1'b0, 3, 5, -1, -1, -1);
        check("stall_round10", cap[10], FIPS_R10);

        run_key(FIPS_KEY, 1'b0, -1, 0, 6, -1, -1);
        check("inject_round10", cap[10], FIPS_R10);

        run_key(FIPS_KEY, 1'b0, -1, 0, -1, 5, -1);
        run_key(FIPS_KEY, 1'b0, -1, 0, -1, -1, -1);
        check("restart_round1", cap[1], FIPS_R1);

`ifdef AES_KEY_REPLAY_EN
        run_key(FIPS_KEY, 1'b0, -1, 0, -1, -1, 7);
        check("replay_round1", cap[1], FIPS_R1);
        check("replay_round0", cap[0], FIPS_KEY);
`endif

        for (int k = 0; k < 6; k++)
            run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, 0, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Iterative AES-128 key schedule sitting directly upstream of the AddroundKey stage.
- Accepts a 128-bit cipher key and emits round keys 0..10 in sequence on byte ports K0..KF, which wire straight into AddroundKey.
- One new round key is computed per accepted transfer, using a valid/ready handshake towards the round controller.

Parameters:
- NR, 10, number of rounds; the last round index emitted is NR (fixed at 10 for AES-128; any other value is unsupported).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- key_in  input  128  cipher key; bits [127:120] map to byte 0
- key_valid  input  1  key_in is valid
- key_ready  output  1  block is idle and can accept a key
- K0..KF  output  8 each  current round key bytes; K0 is byte 0 (column 0, row 0), KF is byte 15
- rk_round  output  4  index (0..10) of the round key on K0..KF
- rk_valid  output  1  K0..KF and rk_round are valid
- rk_ready  input  1  consumer takes the current round key
- replay  input  1  restart from round 0 with the cached key (optional feature only)

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, K0..KF=00, rk_round=0, rk_valid=0, key_ready=1, rcon=01.
- States:
  - IDLE: key_ready=1, rk_valid=0.
  - ACTIVE: key_ready=0, rk_valid=1.
- IDLE -> ACTIVE: on key_valid&&key_ready at edge t, key_in is registered into K0..KF, rk_round=0, rcon=01. rk_valid is high from t+1. Latency from key to round-key-0 is 1 cycle.
- ACTIVE, transfer (rk_valid&&rk_ready) with rk_round<10:
  - Next edge loads round key r+1; rk_round increments; rcon updates to xtime(rcon), giving the sequence 01,02,04,08,10,20,40,80,1B,36.
  - With rk_ready held high, one key is emitted per cycle; all 11 keys take 11 cycles.
- ACTIVE, no transfer: all outputs hold. Stalls are unbounded.
- ACTIVE, transfer with rk_round==10: next edge moves to IDLE with rk_valid=0 and key_ready=1. K0..KF and rk_round hold the round-10 values.
- Next-key arithmetic, with words w0={K0..K3}, w1={K4..K7}, w2={K8..KB}, w3={KC..KF}:
  - t = SubWord(RotWord(w3)), where RotWord(w3) = {KD,KE,KF,KC}.
  - t[31:24] ^= rcon.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - The whole step is combinational from the registered key and completes in one cycle, using 4 S-box instances.
- key_valid asserted in ACTIVE: ignored, no effect on the sequence.
- rk_ready asserted in IDLE: ignored.
- Reset asserted mid-sequence: the next edge forces all reset values, and the sequence is abandoned.

Optional Feature:
- Macro: AES_KEY_REPLAY_EN.
- Defined:
  - A 128-bit register caches key_in on acceptance.
  - replay=1 in either state, at an edge, reloads the cached key: rk_round=0, rcon=01, state=ACTIVE.
  - replay has priority over a simultaneous transfer and over key_valid.
  - replay in IDLE before any key has been loaded replays the reset value 0.
- Undefined: replay is ignored, there is no cache register, and the port remains present.

Decomposition:
- Shared package aes_pkg:
  - byte and word typedefs
  - RCON_INIT = 8'h01
  - LAST_ROUND = 4'd10
  - state encoding IDLE=0, ACTIVE=1
  - xtime function (shift left by 1; XOR 1B if the MSB was set)
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4 times. It is reusable by the SubBytes stage.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1:
  - round 0 equals the key, round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - rk_valid is high for exactly 11 cycles, then key_ready=1.
- All-zero key: round 1 = 62636363626363636263636362636363; rk_round steps 0..10 with no gaps.
- Backpressure: drop rk_ready for 5 cycles after round 3 -> K0..KF and rk_round hold at 3; resuming yields round 4 matching the FIPS value.
- key_valid pulsed with a different key during round 6 -> sequence unaffected; round 10 matches the original key.
- rst_n=0 at round 5 -> next cycle rk_valid=0, K0..KF=00, key_ready=1; a fresh key then restarts at round 0.
- With AES_KEY_REPLAY_EN, replay at round 7 -> next cycle rk_round=0 and K0..KF = 2b7e...4f3c; round 1 again = a0fafe17....
